// File: rtl/game_level_ctrl_if.sv
// Player-side inputs and level-status outputs of the level-progression controller.
interface game_level_ctrl_if #(
  parameter int unsigned COORD_W = 5,
  parameter int unsigned LVL_W   = 2
);
  logic               restart;
  logic [COORD_W-1:0] player_row;
  logic [COORD_W-1:0] player_col;
  logic [LVL_W-1:0]   level_select;
  logic               in_transition;
  logic               level_done;
  logic               game_won;

  modport master (
    output restart, player_row, player_col,
    input  level_select, in_transition, level_done, game_won
  );

  modport slave (
    input  restart, player_row, player_col,
    output level_select, in_transition, level_done, game_won
  );
endinterface

// File: rtl/game_level_ctrl.sv
// Maze level-progression controller: exit-tile dwell detection, timed transition
// between levels, final WON state and soft restart.
module game_level_ctrl #(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned LVL_W        = 2,
  parameter int unsigned COORD_W      = 5,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned TRANS_CYCLES = 16,
  parameter logic [NUM_LEVELS*COORD_W-1:0] EXIT_ROWS = {5'd9, 5'd5, 5'd4},
  parameter logic [NUM_LEVELS*COORD_W-1:0] EXIT_COLS = {5'd9, 5'd2, 5'd2}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  game_level_ctrl_if.slave  bus
);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned TRANS_W = $clog2(TRANS_CYCLES) + 1;

  typedef enum logic [1:0] {S_PLAY, S_TRANS, S_WON} state_t;

  state_t             r_state, w_nxt_state;
  logic [LVL_W-1:0]   r_lvl, w_nxt_lvl;
  logic [HOLD_W-1:0]  r_hold, w_nxt_hold;
  logic [TRANS_W-1:0] r_trans, w_nxt_trans;
  logic               r_done, w_nxt_done;
  logic               r_in_trans, w_nxt_in_trans;
  logic               r_won, w_nxt_won;

  logic [COORD_W-1:0] w_exit_row, w_exit_col;
  logic               w_lvl_valid, w_on_exit, w_last_lvl;

  // Exit lookup with constant indices only, so an illegal level code never selects out of range
  always_comb begin
    w_exit_row = '0;
    w_exit_col = '0;
    for (int i = 0; i < int'(NUM_LEVELS); i++) begin
      if (r_lvl == LVL_W'(i)) begin
        w_exit_row = EXIT_ROWS[i*COORD_W +: COORD_W];
        w_exit_col = EXIT_COLS[i*COORD_W +: COORD_W];
      end
    end
  end

  assign w_lvl_valid = 32'(r_lvl) < NUM_LEVELS;
  assign w_last_lvl  = r_lvl == LVL_W'(NUM_LEVELS - 1);
  assign w_on_exit   = w_lvl_valid && (bus.player_row == w_exit_row) &&
                       (bus.player_col == w_exit_col);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_lvl      = r_lvl;
    w_nxt_hold     = r_hold;
    w_nxt_trans    = r_trans;
    w_nxt_done     = 1'b0;
    w_nxt_in_trans = r_in_trans;
    w_nxt_won      = r_won;
    if (!w_lvl_valid) begin
      w_nxt_state    = S_PLAY;
      w_nxt_lvl      = '0;
      w_nxt_hold     = '0;
      w_nxt_trans    = '0;
      w_nxt_in_trans = 1'b0;
      w_nxt_won      = 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (!w_on_exit) begin
            w_nxt_hold = '0;
          end else if (r_hold != HOLD_W'(HOLD_CYCLES - 1)) begin
            w_nxt_hold = r_hold + HOLD_W'(1);
          end else begin
            w_nxt_done = 1'b1;
            w_nxt_hold = '0;
            if (w_last_lvl) begin
              w_nxt_state = S_WON;
              w_nxt_won   = 1'b1;
            end else begin
              w_nxt_state    = S_TRANS;
              w_nxt_lvl      = r_lvl + LVL_W'(1);
              w_nxt_trans    = '0;
              w_nxt_in_trans = 1'b1;
            end
          end
        end
        S_TRANS: begin
          // Player position is ignored here, so a shared exit tile cannot double-clear
          if (r_trans == TRANS_W'(TRANS_CYCLES - 1)) begin
            w_nxt_state    = S_PLAY;
            w_nxt_in_trans = 1'b0;
            w_nxt_hold     = '0;
            w_nxt_trans    = '0;
          end else begin
            w_nxt_trans = r_trans + TRANS_W'(1);
          end
        end
        S_WON: ;
        default: begin
          w_nxt_state    = S_PLAY;
          w_nxt_lvl      = '0;
          w_nxt_hold     = '0;
          w_nxt_trans    = '0;
          w_nxt_in_trans = 1'b0;
          w_nxt_won      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || bus.restart) begin
      r_state    <= S_PLAY;
      r_lvl      <= '0;
      r_hold     <= '0;
      r_trans    <= '0;
      r_done     <= 1'b0;
      r_in_trans <= 1'b0;
      r_won      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_lvl      <= w_nxt_lvl;
      r_hold     <= w_nxt_hold;
      r_trans    <= w_nxt_trans;
      r_done     <= w_nxt_done;
      r_in_trans <= w_nxt_in_trans;
      r_won      <= w_nxt_won;
    end
  end

  assign bus.level_select  = r_lvl;
  assign bus.in_transition = r_in_trans;
  assign bus.level_done    = r_done;
  assign bus.game_won      = r_won;
endmodule
